// File: rtl/wave_dds_pkg.sv
// Shared types and default sizes for the waveform DDS controller.
package wave_dds_pkg;

  localparam int unsigned DEF_PHASE_W = 32;
  localparam int unsigned DEF_ADDR_W  = 11;
  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned ROM_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dds_state_e;

endpackage

// File: rtl/wave_dds_ctrl_if.sv
// Waveform pROM bus: address/enables from the controller, sample data back.
interface wave_dds_ctrl_if #(
  parameter int unsigned ADDR_W = wave_dds_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = wave_dds_pkg::DEF_DATA_W
);

  logic [ADDR_W-1:0] rom_ad;
  logic              rom_ce;
  logic              rom_oce;
  logic              rom_reset;
  logic [DATA_W-1:0] rom_dout;

  modport master (
    output rom_ad,
    output rom_ce,
    output rom_oce,
    output rom_reset,
    input  rom_dout
  );

  modport slave (
    input  rom_ad,
    input  rom_ce,
    input  rom_oce,
    input  rom_reset,
    output rom_dout
  );

endinterface

// File: rtl/dds_amp_scale.sv
// Final pipeline stage: sample x amplitude, round half up, saturate, register.
module dds_amp_scale #(
  parameter int unsigned DATA_W = wave_dds_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] amp,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out
);

  logic [2*DATA_W-1:0] prod;
  logic [DATA_W:0]     rounded;

  always_comb begin
    prod    = sample * amp;
    rounded = {1'b0, prod[2*DATA_W-1 -: DATA_W]} + {{DATA_W{1'b0}}, prod[DATA_W-1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        data_out <= rounded[DATA_W] ? '1 : rounded[DATA_W-1:0];
      end
    end
  end

endmodule

// File: rtl/wave_dds_ctrl.sv
// Phase-accumulator DDS controller driving an external waveform pROM.
// Optional sync_o phase-wrap marker is built when DDS_SYNC_OUT_EN is defined.
module wave_dds_ctrl
  import wave_dds_pkg::*;
#(
  parameter int unsigned PHASE_W = DEF_PHASE_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               sample_en,
  input  logic [PHASE_W-1:0] ftw,
  input  logic               ftw_load,
  input  logic [ADDR_W-1:0]  phase_ofs,
  input  logic [DATA_W-1:0]  amp,
  wave_dds_ctrl_if.master    rom,
  output logic [DATA_W-1:0]  dac_data,
  output logic               dac_valid,
  output logic               busy
`ifdef DDS_SYNC_OUT_EN
  ,
  output logic               sync_o
`endif
);

  dds_state_e         state;
  logic [PHASE_W-1:0] phase_acc;
  logic [PHASE_W-1:0] ftw_act;
  logic [PHASE_W-1:0] ftw_pend;
  logic               pend_flag;
  logic               s1;
  logic               s2;
  logic               accept;
  logic               wrap;
  logic [PHASE_W:0]   phase_sum;

  always_comb begin
    accept    = (state == RUN) && sample_en;
    phase_sum = {1'b0, phase_acc} + {1'b0, ftw_act};
    wrap      = phase_sum[PHASE_W];
  end

  assign busy        = (state != IDLE);
  assign rom.rom_oce = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      phase_acc     <= '0;
      ftw_act       <= '0;
      ftw_pend      <= '0;
      pend_flag     <= 1'b0;
      s1            <= 1'b0;
      s2            <= 1'b0;
      rom.rom_ad    <= '0;
      rom.rom_ce    <= 1'b0;
      rom.rom_reset <= 1'b1;
    end else begin
      rom.rom_reset <= 1'b0;
      rom.rom_ce    <= accept;
      s1            <= accept;
      s2            <= s1;

      if (accept) begin
        rom.rom_ad <= phase_acc[PHASE_W-1 -: ADDR_W] + phase_ofs;
        phase_acc  <= phase_sum[PHASE_W-1:0];
      end

      // Outside IDLE a new word waits for the next accumulator carry-out;
      // a load on the wrap edge itself is kept pending for the following wrap.
      if (state == IDLE) begin
        if (ftw_load) begin
          ftw_act   <= ftw;
          ftw_pend  <= ftw;
          pend_flag <= 1'b0;
        end
      end else begin
        if (accept && wrap && pend_flag) begin
          ftw_act   <= ftw_pend;
          pend_flag <= 1'b0;
        end
        if (ftw_load) begin
          ftw_pend  <= ftw;
          pend_flag <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            phase_acc <= '0;
          end
        end
        RUN: begin
          if (stop) state <= DRAIN;
        end
        DRAIN: begin
          if (!s1 && !s2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dds_amp_scale #(
    .DATA_W(DATA_W)
  ) u_amp_scale (
    .clk      (clk),
    .reset    (reset),
    .valid_in (s2),
    .sample   (rom.rom_dout),
    .amp      (amp),
    .data_out (dac_data),
    .valid_out(dac_valid)
  );

`ifdef DDS_SYNC_OUT_EN
  logic w1;
  logic w2;

  always_ff @(posedge clk) begin
    if (reset) begin
      w1     <= 1'b0;
      w2     <= 1'b0;
      sync_o <= 1'b0;
    end else begin
      w1     <= accept && wrap;
      w2     <= w1;
      sync_o <= s2 && w2;
    end
  end
`endif

endmodule

// File: tb/tb_wave_dds_ctrl.sv
// Randomised bench for wave_dds_ctrl against a transaction-level DDS model.
module tb_wave_dds_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, stop, sample_en, ftw_load;
  logic [31:0] ftw;
  logic [10:0] phase_ofs;
  logic [7:0]  amp;
  logic [7:0]  dac_data;
  logic        dac_valid, busy;
`ifdef DDS_SYNC_OUT_EN
  logic        sync_o;
`endif

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  logic [7:0] mem [2048];

  wave_dds_ctrl_if #(.ADDR_W(11), .DATA_W(8)) rom_if ();

  wave_dds_ctrl #(.PHASE_W(32), .ADDR_W(11), .DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .sample_en(sample_en),
    .ftw      (ftw),
    .ftw_load (ftw_load),
    .phase_ofs(phase_ofs),
    .amp      (amp),
    .rom      (rom_if),
    .dac_data (dac_data),
    .dac_valid(dac_valid),
    .busy     (busy)
`ifdef DDS_SYNC_OUT_EN
    ,
    .sync_o   (sync_o)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural pROM, one-cycle read latency.
  always @(posedge clk) begin
    if (rom_if.rom_reset) rom_if.rom_dout <= '0;
    else if (rom_if.rom_ce) rom_if.rom_dout <= mem[rom_if.rom_ad];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  // Reference model: mode 0=stopped 1=running 2=finishing
  int          m_mode;
  longint      m_phase, m_act, m_pend;
  bit          m_pflag;
  bit          p1_v, p1_w, p2_v, p2_w;
  int          p1_a, p2_a;
  int          e_ad, e_data;
  bit          e_ce, e_busy, e_rst, e_dv, e_sync;

  function automatic int scale(int d, int a);
    int r;
    r = (d * a + 128) / 256;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic model_step();
    bit     acc, empty, wr;
    longint s;
    if (reset) begin
      m_mode = 0; m_phase = 0; m_act = 0; m_pend = 0; m_pflag = 0;
      p1_v = 0; p2_v = 0; p1_w = 0; p2_w = 0;
      e_ad = 0; e_ce = 0; e_busy = 0; e_rst = 1; e_dv = 0; e_data = 0; e_sync = 0;
      return;
    end
    e_rst  = 0;
    acc    = (m_mode == 1) && sample_en;
    e_dv   = p2_v;
    if (p2_v) e_data = scale(int'(mem[p2_a]), int'(amp));
    e_sync = p2_v && p2_w;
    empty  = !p1_v && !p2_v;
    p2_v = p1_v; p2_a = p1_a; p2_w = p1_w;
    p1_v = acc;
    wr   = 0;
    if (acc) begin
      p1_a    = int'(((m_phase >> 21) + longint'(phase_ofs)) % 2048);
      s       = m_phase + m_act;
      wr      = (s >= 64'h1_0000_0000);
      p1_w    = wr;
      m_phase = s % 64'h1_0000_0000;
      e_ad    = p1_a;
    end
    if (m_mode == 0) begin
      if (ftw_load) begin m_act = ftw; m_pend = ftw; m_pflag = 0; end
    end else begin
      if (acc && wr && m_pflag) begin m_act = m_pend; m_pflag = 0; end
      if (ftw_load) begin m_pend = ftw; m_pflag = 1; end
    end
    case (m_mode)
      0: if (start) begin m_mode = 1; m_phase = 0; end
      1: if (stop) m_mode = 2;
      default: if (empty) m_mode = 0;
    endcase
    e_busy = (m_mode != 0);
    e_ce   = acc;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("busy",      busy,             e_busy);
    check("rom_oce",   rom_if.rom_oce,   e_busy);
    check("rom_ce",    rom_if.rom_ce,    e_ce);
    check("rom_reset", rom_if.rom_reset, e_rst);
    check("rom_ad",    rom_if.rom_ad,    e_ad);
    check("dac_valid", dac_valid,        e_dv);
    if (e_dv) check("dac_data", dac_data, e_data);
`ifdef DDS_SYNC_OUT_EN
    check("sync_o", sync_o, e_sync);
`endif
  endtask

  task automatic drive(input bit r, input bit st, input bit sp, input bit se, input bit ld);
    reset = r; start = st; stop = sp; sample_en = se; ftw_load = ld;
    cyc();
  endtask

  task automatic go_idle();
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0);
    check("idle_after_stop", busy, 1'b0);
  endtask

  initial begin
    int trail;
    logic [7:0] amps [3];
    logic [7:0] exps [3];
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    mem[11'h100] = 8'hFF;
    mem[11'h500] = 8'hFF;
    reset = 1; start = 0; stop = 0; sample_en = 0; ftw_load = 0;
    ftw = '0; phase_ofs = '0; amp = 8'hFF;

    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Unit address step, full-scale amplitude.
    ftw = 32'h0020_0000;
    drive(0, 1, 0, 0, 1);
    for (int i = 0; i < 40; i++) drive(0, 0, 0, 1, 0);

    // Two pending loads mid-period, last one wins at the wrap.
    ftw = 32'h0060_0000;
    drive(0, 0, 0, 1, 1);
    for (int i = 0; i < 300; i++) drive(0, 0, 0, 1, 0);
    ftw = 32'h0040_0000;
    drive(0, 0, 0, 1, 1);
    for (int i = 0; i < 1800; i++) drive(0, 0, 0, 1, 0);

    // Stop while streaming: no more than three trailing samples.
    trail = 0;
    drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, 0);
      if (dac_valid) trail++;
    end
    check("drain_trail_le3", (trail <= 3), 1'b1);
    check("drain_idle", busy, 1'b0);

    // Half-period step with offset: addresses 0x100/0x500, ROM holds 0xFF there.
    ftw = 32'h8000_0000; phase_ofs = 11'h100;
    drive(0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0);
    amps[0] = 8'h80; exps[0] = 8'h80;
    amps[1] = 8'h00; exps[1] = 8'h00;
    amps[2] = 8'hFF; exps[2] = 8'hFE;
    for (int k = 0; k < 3; k++) begin
      amp = amps[k];
      for (int i = 0; i < 6; i++) begin
        drive(0, 0, 0, 1, 0);
        if (dac_valid) check("amp_edge", dac_data, exps[k]);
      end
    end
    go_idle();

    // Quarter-period step (sync every 4th sample) and zero tuning word.
    ftw = 32'h4000_0000; phase_ofs = '0; amp = 8'hC3;
    drive(0, 1, 0, 0, 1);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 1, 0);
    go_idle();
    ftw = '0; phase_ofs = 11'h2A5;
    drive(0, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 0);

    // Reset landing on the ROM-read cycle of an in-flight sample.
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    check("reset_no_valid", dac_valid, 1'b0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("reset_rom_reset_low", rom_if.rom_reset, 1'b0);
    ftw = 32'h0020_0000; phase_ofs = 11'h010;
    drive(0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      ftw       = $urandom >> $urandom_range(0, 12);
      phase_ofs = 11'($urandom);
      amp       = 8'($urandom);
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
